// File: rtl/masked_a2b_pkg.sv
// rtl/masked_a2b_pkg.sv - shared constants and state type for the masked A2B converter
//
// Purpose : default word width, round-count helper and FSM state encoding.
// Ports   : none (package).

package masked_a2b_pkg;

   localparam int XLEN_DEFAULT   = 32;
   localparam int ROUNDS_DEFAULT = $clog2(XLEN_DEFAULT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } a2b_state_e;

   // Number of Kogge-Stone rounds needed for a w-bit carry chain.
   function automatic int a2b_rounds(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/masked_a2b_converter_dom_and.sv
// rtl/masked_a2b_converter_dom_and.sv - two-share DOM-AND gate with one register stage
//
// Purpose : (q0 ^ q1) = (x0 ^ x1) & (y0 ^ y1), one cycle after the operands.
// Ports   : clk, rst_n    clock and asynchronous active-low reset
//           clr           synchronous clear of all internal registers
//           x0, x1        shares of operand x
//           y0, y1        shares of operand y
//           z             fresh randomness protecting the cross terms
//           q0, q1        output shares

module dom_and_2s
   import masked_a2b_pkg::*;
#(
   parameter int W = XLEN_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic [W-1:0] x0,
   input  logic [W-1:0] x1,
   input  logic [W-1:0] y0,
   input  logic [W-1:0] y1,
   input  logic [W-1:0] z,
   output logic [W-1:0] q0,
   output logic [W-1:0] q1
);

   logic [W-1:0] in0_d, in0_q;
   logic [W-1:0] in1_d, in1_q;
   logic [W-1:0] cr0_d, cr0_q;
   logic [W-1:0] cr1_d, cr1_q;

   // Cross terms are blinded with z and registered before being combined
   // with the inner terms, so no glitch can momentarily expose x0&y1 ^ x1&y0.
   always_comb begin
      in0_d = x0 & y0;
      in1_d = x1 & y1;
      cr0_d = (x0 & y1) ^ z;
      cr1_d = (x1 & y0) ^ z;
      if (clr) begin
         in0_d = '0;
         in1_d = '0;
         cr0_d = '0;
         cr1_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in0_q <= '0;
         in1_q <= '0;
         cr0_q <= '0;
         cr1_q <= '0;
      end else begin
         in0_q <= in0_d;
         in1_q <= in1_d;
         cr0_q <= cr0_d;
         cr1_q <= cr1_d;
      end
   end

   assign q0 = in0_q ^ cr0_q;
   assign q1 = in1_q ^ cr1_q;

endmodule

// File: rtl/masked_a2b_converter.sv
// rtl/masked_a2b_converter.sv - arithmetic-to-Boolean mask conversion via masked Kogge-Stone subtraction
//
// Purpose : x = rs_s0 - rs_s1 (mod 2^BIT_WIDTH) re-expressed as x = rd_s0 ^ rd_s1.
// Ports   : g_clk, g_resetn  clock and asynchronous active-low reset
//           flush            synchronous abort of the operation in flight
//           valid            operands valid, held until ready
//           rs_s0, rs_s1     arithmetic shares
//           z0, z1, z2       fresh randomness (g path, p path, operand re-sharing)
//           rd_s0, rd_s1     Boolean shares, zero unless ready
//           ready            one-cycle result pulse

module masked_a2b_converter
   import masked_a2b_pkg::*;
#(
   parameter int BIT_WIDTH = XLEN_DEFAULT
) (
   input  logic                 g_clk,
   input  logic                 g_resetn,
   input  logic                 flush,
   input  logic                 valid,
   input  logic [BIT_WIDTH-1:0] rs_s0,
   input  logic [BIT_WIDTH-1:0] rs_s1,
   input  logic [BIT_WIDTH-1:0] z0,
   input  logic [BIT_WIDTH-1:0] z1,
   input  logic [BIT_WIDTH-1:0] z2,
   output logic [BIT_WIDTH-1:0] rd_s0,
   output logic [BIT_WIDTH-1:0] rd_s1,
   output logic                 ready
);

   localparam int W      = BIT_WIDTH;
   localparam int ROUNDS = a2b_rounds(BIT_WIDTH);

   a2b_state_e state_d, state_q;

   logic [ROUNDS-1:0] cnt_d, cnt_q;
   logic [W-1:0]      a0_d, a0_q;              // a = (rs_s0, 0); share 1 is constant zero
   logic [W-1:0]      b0_d, b0_q, b1_d, b1_q;  // b = (z2, rs_s1 ^ z2)
   logic [W-1:0]      po0_d, po0_q, po1_d, po1_q;
   logic [W-1:0]      gh0_d, gh0_q, gh1_d, gh1_q;

   logic              start, abort, last_round;
   logic [ROUNDS-1:0] shamt;
   logic [W-1:0]      pre_p0, pre_p1;
   logic [W-1:0]      g0_cur, g1_cur, p0_cur, p1_cur;
   logic [W-1:0]      gx0, gx1, gy0, gy1;
   logic [W-1:0]      dg0, dg1, dp0, dp1;

   assign start      = (state_q == IDLE) && valid && !flush;
   assign abort      = (state_q != IDLE) && (flush || !valid);
   assign last_round = (cnt_q == ROUNDS'(ROUNDS - 1));
   assign shamt      = ROUNDS'(1) << cnt_q;

   // Live g is the previous g held beside the DOM stage, XORed share-wise with
   // the freshly registered DOM product.
   assign g0_cur = gh0_q ^ dg0;
   assign g1_cur = gh1_q ^ dg1;

   // Round 0 starts from the PRE propagate; later rounds use the DOM output.
   assign p0_cur = (cnt_q == '0) ? po0_q : dp0;
   assign p1_cur = (cnt_q == '0) ? po1_q : dp1;

   // p = a ^ ~b, inversion applied to share 0 only.
   assign pre_p0 = a0_q ^ ~b0_q;
   assign pre_p1 = b1_q;

   // ---------------- state register ----------------
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = PRE;
         PRE:  state_d = ITER;
         ITER: if (last_round) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      a0_d  = a0_q;
      b0_d  = b0_q;
      b1_d  = b1_q;
      po0_d = po0_q;
      po1_d = po1_q;
      gh0_d = gh0_q;
      gh1_d = gh1_q;
      cnt_d = cnt_q;
      // Kogge-Stone operands by default; PRE reuses the same gate for a & ~b.
      gx0   = p0_cur;
      gx1   = p1_cur;
      gy0   = g0_cur << shamt;
      gy1   = g1_cur << shamt;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a0_d = rs_s0;
               b0_d = z2;
               b1_d = rs_s1 ^ z2;
            end
         end
         PRE: begin
            gx0   = a0_q;
            gx1   = '0;
            gy0   = ~b0_q;
            gy1   = b1_q;
            po0_d = pre_p0;
            po1_d = pre_p1;
            // Carry-in of 1: g[0] | p[0] equals g[0] ^ p[0] because they are
            // disjoint, so the fold stays linear and share-wise.
            gh0_d = {{(W-1){1'b0}}, pre_p0[0]};
            gh1_d = {{(W-1){1'b0}}, pre_p1[0]};
            cnt_d = '0;
         end
         ITER: begin
            gh0_d = g0_cur;
            gh1_d = g1_cur;
            cnt_d = last_round ? '0 : cnt_q + ROUNDS'(1);
         end
         DONE: ;
         default: ;
      endcase

      if (abort) begin
         a0_d  = '0;
         b0_d  = '0;
         b1_d  = '0;
         po0_d = '0;
         po1_d = '0;
         gh0_d = '0;
         gh1_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         cnt_q <= '0;
         a0_q  <= '0;
         b0_q  <= '0;
         b1_q  <= '0;
         po0_q <= '0;
         po1_q <= '0;
         gh0_q <= '0;
         gh1_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         a0_q  <= a0_d;
         b0_q  <= b0_d;
         b1_q  <= b1_d;
         po0_q <= po0_d;
         po1_q <= po1_d;
         gh0_q <= gh0_d;
         gh1_q <= gh1_d;
      end
   end

   // g path: a & ~b in PRE, p & (g << d) in ITER, selected by the mux above.
   dom_and_2s #(.W(W)) u_dom_g (
      .clk   (g_clk),
      .rst_n (g_resetn),
      .clr   (abort),
      .x0    (gx0),
      .x1    (gx1),
      .y0    (gy0),
      .y1    (gy1),
      .z     (z0),
      .q0    (dg0),
      .q1    (dg1)
   );

   // p path: p & (p << d); the result of the final round is never consumed.
   dom_and_2s #(.W(W)) u_dom_p (
      .clk   (g_clk),
      .rst_n (g_resetn),
      .clr   (abort),
      .x0    (p0_cur),
      .x1    (p1_cur),
      .y0    (p0_cur << shamt),
      .y1    (p1_cur << shamt),
      .z     (z1),
      .q0    (dp0),
      .q1    (dp1)
   );

   // ---------------- outputs ----------------
   // Gated by the state register alone so an asynchronous reset clears them at once.
   always_comb begin
      ready = (state_q == DONE);
      rd_s0 = '0;
      rd_s1 = '0;
      if (ready) begin
         rd_s0 = po0_q ^ {g0_cur[W-2:0], 1'b1};
         rd_s1 = po1_q ^ {g1_cur[W-2:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_masked_a2b_converter.sv
// tb/tb_masked_a2b_converter.sv - directed self-checking bench for masked_a2b_converter

module tb_masked_a2b_converter;

   logic        g_clk;
   logic        g_resetn;
   logic        flush;
   logic        valid;
   logic [31:0] rs_s0, rs_s1;
   logic [31:0] z0, z1, z2;
   logic [31:0] rd_s0, rd_s1;
   logic        ready;

   int errors = 0;
   int checks = 0;
   int zmode  = 0;   // 0 random, 1 all zero, 2 all ones

   logic [31:0] rd0_zero_run, rd0_ones_run, rd0_tmp;

   masked_a2b_converter #(.BIT_WIDTH(32)) dut (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .flush    (flush),
      .valid    (valid),
      .rs_s0    (rs_s0),
      .rs_s1    (rs_s1),
      .z0       (z0),
      .z1       (z1),
      .z2       (z2),
      .rd_s0    (rd_s0),
      .rd_s1    (rd_s1),
      .ready    (ready)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic drive_z();
      case (zmode)
         1:       begin z0 = '0; z1 = '0; z2 = '0; end
         2:       begin z0 = '1; z1 = '1; z2 = '1; end
         default: begin z0 = $urandom; z1 = $urandom; z2 = $urandom; end
      endcase
   endtask

   // Called at a negedge: this cycle becomes T for the new operation.
   task automatic start(input logic [31:0] s0, input logic [31:0] s1);
      valid = 1'b1;
      rs_s0 = s0;
      rs_s1 = s1;
      drive_z();
   endtask

   // Advances to the negedge of T+7, checking no early ready and the result there.
   task automatic wait_done(input logic [31:0] exp, input string tag, output logic [31:0] rd0);
      logic early;
      early = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge g_clk); #1 drive_z();
         @(negedge g_clk);
         if (k < 7) early = early | ready;
      end
      check({tag, "_early_ready"}, {31'd0, early}, 32'd0);
      check({tag, "_ready_T7"}, {31'd0, ready}, 32'd1);
      check({tag, "_xor"}, rd_s0 ^ rd_s1, exp);
      rd0 = rd_s0;
   endtask

   task automatic check_idle_out(input string tag);
      check({tag, "_ready0"}, {31'd0, ready}, 32'd0);
      check({tag, "_rd_s0_zero"}, rd_s0, 32'd0);
      check({tag, "_rd_s1_zero"}, rd_s1, 32'd0);
   endtask

   task automatic run_op(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] exp,
                         input string tag, output logic [31:0] rd0);
      start(s0, s1);
      wait_done(exp, tag, rd0);
      valid = 1'b0;
      @(posedge g_clk);
      @(negedge g_clk);
      check_idle_out({tag, "_after"});
   endtask

   initial begin
      g_resetn = 1'b0;
      flush    = 1'b0;
      valid    = 1'b0;
      rs_s0    = '0;
      rs_s1    = '0;
      z0 = '0; z1 = '0; z2 = '0;
      repeat (2) @(posedge g_clk);
      @(negedge g_clk);
      check_idle_out("reset");
      g_resetn = 1'b1;
      @(negedge g_clk);

      // Basic subtraction and wrap-around
      run_op(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, "sub5_3", rd0_tmp);
      run_op(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "wrap0_1", rd0_tmp);
      run_op(32'h0000_1000, 32'h0000_0001, 32'h0000_0FFF, "borrow_chain", rd0_tmp);

      // Same operands, extreme randomness: result identical, share 0 must differ
      zmode = 1;
      run_op(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "msb_z0", rd0_zero_run);
      zmode = 2;
      run_op(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "msb_z1", rd0_ones_run);
      zmode = 0;
      checks++;
      assert (rd0_zero_run !== rd0_ones_run) else begin
         errors++;
         $error("FAIL msb_share_differs: observed=%08h expected_not=%08h", rd0_ones_run, rd0_zero_run);
      end

      // Flush in T+4, new operation accepted in T+5, done in T+12
      begin
         logic early;
         early = 1'b0;
         start(32'h0000_00AA, 32'h0000_0055);
         for (int k = 1; k <= 4; k++) begin
            @(posedge g_clk); #1 drive_z();
            @(negedge g_clk);
            early = early | ready;
         end
         check("flush_early_ready", {31'd0, early}, 32'd0);
         flush = 1'b1;
         @(posedge g_clk); #1 drive_z();
         @(negedge g_clk);
         flush = 1'b0;
         check_idle_out("flush_T5");
         rs_s0 = 32'h0000_0009;
         rs_s1 = 32'h0000_0004;
         wait_done(32'h0000_0005, "post_flush", rd0_tmp);
         valid = 1'b0;
         @(posedge g_clk);
         @(negedge g_clk);
         check_idle_out("post_flush_after");
      end

      // flush coinciding with DONE: ready still shown, no restart
      start(32'h0000_0100, 32'h0000_0001);
      for (int k = 1; k <= 6; k++) begin
         @(posedge g_clk); #1 drive_z();
      end
      @(posedge g_clk); #1 flush = 1'b1;
      @(negedge g_clk);
      check("flush_done_ready", {31'd0, ready}, 32'd1);
      check("flush_done_xor", rd_s0 ^ rd_s1, 32'h0000_00FF);
      @(posedge g_clk); #1;
      flush = 1'b0;
      valid = 1'b0;
      @(negedge g_clk);
      check_idle_out("flush_done_after");

      // Asynchronous reset during ITER
      start(32'h1234_0000, 32'h0000_0001);
      repeat (3) @(posedge g_clk);
      @(negedge g_clk);
      #2 g_resetn = 1'b0;
      #1 check_idle_out("areset_iter");
      valid = 1'b0;
      @(posedge g_clk);
      @(negedge g_clk);
      g_resetn = 1'b1;
      @(negedge g_clk);
      run_op(32'h0000_0007, 32'h0000_0003, 32'h0000_0004, "after_reset", rd0_tmp);

      // Asynchronous reset while ready is high: outputs drop immediately
      start(32'h0000_0010, 32'h0000_0008);
      wait_done(32'h0000_0008, "pre_areset_done", rd0_tmp);
      #2 g_resetn = 1'b0;
      #1 check_idle_out("areset_done");
      valid = 1'b0;
      @(posedge g_clk);
      @(negedge g_clk);
      g_resetn = 1'b1;
      @(negedge g_clk);

      // Back-to-back: pulses at T+7 and T+15, zero in between
      start(32'h1234_5678, 32'h1111_1111);
      wait_done(32'h0123_4567, "b2b_first", rd0_tmp);
      rs_s0 = 32'h0000_0000;
      rs_s1 = 32'hFFFF_FFFF;
      @(posedge g_clk); #1 drive_z();
      @(negedge g_clk);
      check_idle_out("b2b_gap");
      wait_done(32'h0000_0001, "b2b_second", rd0_tmp);
      valid = 1'b0;
      @(posedge g_clk);
      @(negedge g_clk);
      check_idle_out("b2b_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
